debounce_scheduler: RTL and testbench
=====================================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 SHALL have parameter p_channels, default 4, number of button inputs (>=2).
REQ-002 SHALL have parameter p_counter_width, default 2, per-channel stability counter width (>=2).
REQ-003 SHALL have parameter p_tick_div, default 4, clock cycles per scan step (>=1).
REQ-004 SHALL have parameter p_fifo_depth, default 4, event queue entries (power of two, >=2).
REQ-005 SHALL have i_w_clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have i_w_reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have i_w_in  input  p_channels  raw asynchronous button levels.
REQ-008 SHALL have o_w_state  output  p_channels  debounced level per channel.
REQ-009 SHALL have o_w_evt_valid  output  1  event queue non-empty.
REQ-010 SHALL have o_w_evt_channel  output  clog2(p_channels)  channel index of head event.
REQ-011 SHALL have o_w_evt_press  output  1  head event polarity; 1 = rising (press), 0 = falling (release).
REQ-012 SHALL have i_w_evt_ready  input  1  consumer accepts head event.
REQ-013 SHALL have o_w_overflow  output  1  sticky flag: an event was dropped.
REQ-014 SHALL have i_w_clear_overflow  input  1  synchronous clear of o_w_overflow.

Function
REQ-015 SHALL pass each i_w_in bit through a 2-flop synchronizer; the scan uses only synchronized values.
REQ-016 SHALL run a prescaler counting 0..p_tick_div-1, wrapping; a scan step occurs in the cycle the prescaler equals p_tick_div-1.
REQ-017 SHALL hold a scan pointer 0..p_channels-1, advancing by 1 after each scan step, wrapping from p_channels-1 to 0; each channel is scanned once every p_channels*p_tick_div cycles.
REQ-018 SHALL keep one p_counter_width-bit counter per channel; only the pointed channel's counter and state update on a scan step.
REQ-019 At a scan step, synchronized input == o_w_state[ptr] SHALL clear counter[ptr].
REQ-020 At a scan step, input != state with counter[ptr] MSB = 0 SHALL increment counter[ptr].
REQ-021 At a scan step, input != state with counter[ptr] MSB = 1 SHALL toggle o_w_state[ptr], clear counter[ptr], and push event {ptr, new level}.
REQ-022 A toggle SHALL therefore require 2^(p_counter_width-1)+1 consecutive disagreeing scans of that channel; any agreeing scan restarts the count.
REQ-023 Event queue SHALL be FIFO-ordered; o_w_evt_valid = (count != 0); o_w_evt_channel/o_w_evt_press SHALL show the oldest entry.
REQ-024 Pop SHALL occur when o_w_evt_valid && i_w_evt_ready at a clock edge.
REQ-025 A pushed event SHALL be visible (o_w_evt_valid high) in the same cycle o_w_state reflects the toggle, i.e. on the edge following the scan step.
REQ-026 Simultaneous push and pop SHALL both occur; count unchanged; legal when full.
REQ-027 Push when full without pop SHALL drop the new event, leave queue unchanged, and set o_w_overflow; o_w_state SHALL still toggle.
REQ-028 Pop when empty SHALL have no effect.
REQ-029 o_w_overflow SHALL stay 1 until i_w_clear_overflow; if a drop and a clear coincide, overflow SHALL remain 1.
REQ-030 Head outputs SHALL remain stable while o_w_evt_valid && !i_w_evt_ready.

Reset
REQ-031 i_w_reset low SHALL immediately clear synchronizers, prescaler, scan pointer, all counters, o_w_state, queue (o_w_evt_valid=0), o_w_overflow.
REQ-032 After reset deassertion, first scan step SHALL occur p_tick_div cycles later on channel 0.
REQ-033 Reset asserted mid-count or with queued events SHALL discard all progress and events; no event SHALL be emitted for inputs already high at reset release until they complete REQ-022 qualification.

Verification (defaults: 4 channels, width 2, div 4, depth 4; channel scan period 16 cycles)
REQ-034 Hold i_w_in[2]=1 steady, ready=1 -> o_w_state[2] rises after third scan of channel 2 seeing 1; one event {ch=2,press=1}; no other channel changes.
REQ-035 i_w_in[1] high for exactly 2 channel-1 scans then low -> no toggle, no event, counter[1] returns to 0.
REQ-036 ready=0, generate 5 qualified toggles on channels 0..3,0 -> 4 events held in order, fifth dropped, o_w_overflow=1, o_w_state reflects all 5 toggles; then ready=1 drains 4 events in order.
REQ-037 Queue full, push and pop in same cycle -> count stays 4, no overflow, new event appended at tail.
REQ-038 Assert reset while counter[3]=1 and 2 events queued -> all outputs 0 asynchronously; after release, channel 3 needs full 3 scans to toggle.
REQ-039 i_w_clear_overflow coincident with a drop -> o_w_overflow stays 1; clear alone next cycle -> 0.

Source files
------------

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: time-multiplexed debouncer for p_channels buttons that queues
// press/release events in a small FIFO with a sticky overflow flag.
module debounce_scheduler #(
   parameter int p_channels      = 4,
   parameter int p_counter_width = 2,
   parameter int p_tick_div      = 4,
   parameter int p_fifo_depth    = 4
) (
   input  logic                          i_w_clk,
   input  logic                          i_w_reset,
   input  logic [p_channels-1:0]         i_w_in,
   output logic [p_channels-1:0]         o_w_state,
   output logic                          o_w_evt_valid,
   output logic [$clog2(p_channels)-1:0] o_w_evt_channel,
   output logic                          o_w_evt_press,
   input  logic                          i_w_evt_ready,
   output logic                          o_w_overflow,
   input  logic                          i_w_clear_overflow
);
   localparam int lp_cw = $clog2(p_channels);
   localparam int lp_dw = p_tick_div > 1 ? $clog2(p_tick_div) : 1;
   localparam int lp_fw = $clog2(p_fifo_depth);

   logic [p_channels-1:0]      r_sync1, r_sync2, r_state;
   logic [lp_dw-1:0]           r_div;
   logic [lp_cw-1:0]           r_ptr;
   logic [p_counter_width-1:0] r_cnt [p_channels];
   logic [lp_cw:0]             r_fifo [p_fifo_depth];
   logic [lp_fw-1:0]           r_wr, r_rd;
   logic [lp_fw:0]             r_count;
   logic                       r_ovf;
   logic                       w_step, w_agree, w_msb, w_toggle, w_pop, w_full, w_push, w_drop;
   logic [lp_cw:0]             w_head;

   always_comb begin
      w_step   = r_div == lp_dw'(p_tick_div - 1);
      w_agree  = r_sync2[r_ptr] == r_state[r_ptr];
      w_msb    = r_cnt[r_ptr][p_counter_width-1];
      w_toggle = w_step && !w_agree && w_msb;
      w_pop    = o_w_evt_valid && i_w_evt_ready;
      w_full   = r_count == (lp_fw + 1)'(p_fifo_depth);
      // a pop in the same edge frees the slot, so a full queue still accepts
      w_push   = w_toggle && (!w_full || w_pop);
      w_drop   = w_toggle && !w_push;
      w_head   = r_fifo[r_rd];
   end

   assign o_w_state       = r_state;
   assign o_w_evt_valid   = r_count != '0;
   assign o_w_evt_channel = o_w_evt_valid ? w_head[lp_cw:1] : '0;
   assign o_w_evt_press   = o_w_evt_valid & w_head[0];
   assign o_w_overflow    = r_ovf;

   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_state <= '0;
         r_div   <= '0;
         r_ptr   <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < p_channels; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= i_w_in;
         r_sync2 <= r_sync1;
         r_div   <= w_step ? '0 : r_div + 1'b1;
         if (w_step) begin
            r_ptr        <= r_ptr == lp_cw'(p_channels - 1) ? '0 : r_ptr + 1'b1;
            r_cnt[r_ptr] <= (w_agree || w_msb) ? '0 : r_cnt[r_ptr] + 1'b1;
         end
         if (w_toggle) r_state[r_ptr] <= ~r_state[r_ptr];
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (lp_fw + 1)'(w_push) - (lp_fw + 1)'(w_pop);
         r_ovf   <= w_drop || (r_ovf && !i_w_clear_overflow);
      end
   end

   always_ff @(posedge i_w_clk) begin
      if (w_push) r_fifo[r_wr] <= {r_ptr, ~r_state[r_ptr]};
   end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: random and directed stimulus against a scan-level reference
// model; a negedge monitor compares DUT outputs with the model and an event scoreboard.
module tb_debounce_scheduler;
   localparam int N = 4, W = 2, D = 4, Q = 4;
   localparam int NEED = 2 ** (W - 1) + 1;

   logic         clk = 0, rst_n = 0, ready = 0, clr = 0;
   logic [N-1:0] in = '0, st;
   logic         valid, press, ovf;
   logic [1:0]   ch;
   int           errors = 0, checks = 0;

   debounce_scheduler #(.p_channels(N), .p_counter_width(W), .p_tick_div(D), .p_fifo_depth(Q)) dut (
      .i_w_clk(clk), .i_w_reset(rst_n), .i_w_in(in), .o_w_state(st), .o_w_evt_valid(valid),
      .o_w_evt_channel(ch), .o_w_evt_press(press), .i_w_evt_ready(ready), .o_w_overflow(ovf),
      .i_w_clear_overflow(clr));

   always #5 clk = ~clk;

   int           e;
   logic [N-1:0] hist[$];
   int           run[N];
   logic [N-1:0] m_state;
   int           m_cnt;
   logic         m_ovf;
   logic [2:0]   exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_state", st, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ch", ch, 0);
      chk("rst_press", press, 0);
   endtask

   // reference model: every D-th edge scans channel (scan# mod N) using the input seen two edges earlier
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         e = 0;
         hist.delete();
         for (int i = 0; i < N; i++) run[i] = 0;
         m_state = '0;
         m_cnt = 0;
         m_ovf = 0;
         exp_q.delete();
      end else begin
         logic         pop, tog, push, drop;
         logic [N-1:0] seen;
         int           c;
         c = 0;
         tog = 0;
         e++;
         hist.push_back(in);
         seen = e >= 3 ? hist[e-3] : '0;
         pop = m_cnt > 0 && ready;
         if (e % D == 0) begin
            c = (e / D - 1) % N;
            if (seen[c] != m_state[c]) begin
               run[c]++;
               if (run[c] == NEED) begin
                  m_state[c] = ~m_state[c];
                  run[c] = 0;
                  tog = 1;
               end
            end else run[c] = 0;
         end
         push = tog && (m_cnt < Q || pop);
         drop = tog && !push;
         m_cnt = m_cnt - int'(pop) + int'(push);
         if (push) exp_q.push_back({c[1:0], m_state[c]});
         m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("state", st, m_state);
         chk("valid", valid, m_cnt != 0);
         chk("overflow", ovf, m_ovf);
         if (exp_q.size() > 0) begin
            chk("head", {ch, press}, exp_q[0]);
            if (ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int pct;
      #1 chk_reset_outputs();
      step();
      step();
      rst_n = 1;
      ready = 1;
      in = 4'b0100;
      repeat (43) @(posedge clk);
      @(negedge clk);
      chk("ch2_before_third_scan", st, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      chk("ch2_after_third_scan", st, 4'b0100);
      repeat (20) step();
      in = 4'b0110;
      repeat (20) step();
      in = 4'b0100;
      repeat (40) step();
      ready = 0;
      in = 4'b1011;
      repeat (70) step();
      in = 4'b1010;
      repeat (70) step();
      clr = 1;
      step();
      clr = 0;
      in = 4'b1000;
      clr = 1;
      repeat (70) step();
      clr = 0;
      ready = 1;
      repeat (10) step();
      ready = 0;
      in = 4'b1111;
      repeat (50) step();
      @(posedge clk);
      #3 rst_n = 0;
      #1 chk_reset_outputs();
      step();
      step();
      rst_n = 1;
      repeat (80) step();
      ready = 1;
      pct = 50;
      for (int k = 0; k < 3000; k++) begin
         step();
         if (k % 200 == 0) pct = $urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) == 0 ? 10 : 90);
         if ($urandom_range(0, 29) == 0) in[$urandom_range(0, N - 1)] ^= 1'b1;
         ready = $urandom_range(0, 99) < pct;
         clr = $urandom_range(0, 49) == 0;
      end
      ready = 1;
      clr = 0;
      for (int k = 0; k < 200 && (exp_q.size() != 0 || valid); k++) step();
      chk("drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
